// File: rtl/pe_array_ctrl.sv
`default_nettype none
// pe_array_ctrl: job sequencer that streams operand vectors into the 16-row bit-fusion PE array,
// aligns flush/bias controls to the array pipeline and buffers finished psums in a 2-entry FIFO. Rev 1.0
module pe_array_ctrl #(
  parameter int PE_ROW      = 16,
  parameter int BITS_ACT    = 8,
  parameter int BITS_WEIGHT = 8,
  parameter int N_BIAS      = 16,
  parameter int BITS_PSUM   = 32,
  parameter int PE_LAT      = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          i_Start,
  input  logic [3:0]                    i_Precision,
  input  logic [15:0]                   i_Steps,
  input  logic [15:0]                   i_Outputs,
  output logic                          o_Busy,
  output logic                          o_Done,
  input  logic                          i_Op_Valid,
  output logic                          o_Op_Ready,
  input  logic [BITS_ACT*PE_ROW-1:0]    i_Op_Act,
  input  logic [BITS_WEIGHT*PE_ROW-1:0] i_Op_Weight,
  input  logic [N_BIAS-1:0]             i_Op_Bias,
  output logic [BITS_ACT*PE_ROW-1:0]    o_Arr_Act,
  output logic [BITS_WEIGHT*PE_ROW-1:0] o_Arr_Weight,
  output logic [3:0]                    o_Arr_Precision,
  output logic [N_BIAS-1:0]             o_Arr_Bias,
  output logic                          o_Arr_Sel_Bias,
  output logic                          o_Arr_Flush,
  input  logic [BITS_PSUM-1:0]          i_Arr_Psum,
  output logic                          o_Res_Valid,
  input  logic                          i_Res_Ready,
  output logic [BITS_PSUM-1:0]          o_Res_Data,
  output logic                          o_Res_Last
);

  localparam int ACC_LAT = PE_LAT + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]           state;
  logic [15:0]          steps, outputs, s_cnt, k_cnt;
  logic [3:0]           prec;
  logic [1:0]           outstanding;
  logic                 zero_done;
  logic [ACC_LAT-1:0]   tag_first, tag_last, tag_job;
  logic [N_BIAS-1:0]    bias_pipe [PE_LAT+1];
  logic [BITS_PSUM-1:0] fifo_data [2];
  logic [1:0]           fifo_last;
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           fifo_cnt;

  logic accept, group_start, step_last, job_last, pop, push, pipe_empty, drain_done;

  assign group_start = (s_cnt == 16'd0);
  assign step_last   = (s_cnt == steps - 16'd1);
  assign job_last    = (k_cnt == outputs - 16'd1);
  assign accept      = i_Op_Valid & o_Op_Ready;
  assign pop         = o_Res_Valid & i_Res_Ready;
  assign push        = tag_last[ACC_LAT-1];
  assign pipe_empty  = ~|(tag_first | tag_last);
  assign drain_done  = (state == S_DRAIN) && pipe_empty && (fifo_cnt == 2'd0);

  // At a group start the FIFO must have room for the result this group will produce.
  assign o_Op_Ready      = (state == S_RUN) && (!group_start || outstanding < 2'd2);
  assign o_Busy          = (state != S_IDLE) && !drain_done;
  assign o_Done          = zero_done | drain_done;
  assign o_Arr_Flush     = (state == S_FLUSH);
  assign o_Arr_Precision = prec;
  assign o_Arr_Sel_Bias  = tag_first[PE_LAT];
  assign o_Arr_Bias      = tag_first[PE_LAT] ? bias_pipe[PE_LAT] : '0;
  assign o_Res_Valid     = (fifo_cnt != 2'd0);
  assign o_Res_Data      = fifo_data[rd_ptr];
  assign o_Res_Last      = fifo_last[rd_ptr] & o_Res_Valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      steps     <= '0;
      outputs   <= '0;
      s_cnt     <= '0;
      k_cnt     <= '0;
      prec      <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_Start) begin
            if (i_Steps == 16'd0 || i_Outputs == 16'd0) begin
              zero_done <= 1'b1;
            end else begin
              steps   <= i_Steps;
              outputs <= i_Outputs;
              prec    <= i_Precision;
              s_cnt   <= '0;
              k_cnt   <= '0;
              state   <= S_FLUSH;
            end
          end
        end
        S_FLUSH: state <= S_RUN;
        S_RUN: begin
          if (accept) begin
            if (step_last) begin
              s_cnt <= '0;
              k_cnt <= k_cnt + 16'd1;
              if (job_last) state <= S_DRAIN;
            end else begin
              s_cnt <= s_cnt + 16'd1;
            end
          end
        end
        default: begin
          if (drain_done) state <= S_IDLE;
        end
      endcase
    end
  end

  // Idle and starved cycles present zero operands so the array accumulates nothing.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_Arr_Act    <= '0;
      o_Arr_Weight <= '0;
      tag_first    <= '0;
      tag_last     <= '0;
      tag_job      <= '0;
      outstanding  <= '0;
      for (int i = 0; i <= PE_LAT; i++) bias_pipe[i] <= '0;
    end else begin
      o_Arr_Act    <= accept ? i_Op_Act : '0;
      o_Arr_Weight <= accept ? i_Op_Weight : '0;
      tag_first    <= {tag_first[ACC_LAT-2:0], accept & group_start};
      tag_last     <= {tag_last[ACC_LAT-2:0], accept & step_last};
      tag_job      <= {tag_job[ACC_LAT-2:0], accept & step_last & job_last};
      bias_pipe[0] <= (accept & group_start) ? i_Op_Bias : '0;
      for (int i = 1; i <= PE_LAT; i++) bias_pipe[i] <= bias_pipe[i-1];
      case ({accept & group_start, pop})
        2'b10:   outstanding <= outstanding + 2'd1;
        2'b01:   outstanding <= outstanding - 2'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= i_Arr_Psum;
        fifo_last[wr_ptr] <= tag_job[ACC_LAT-1];
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_array_ctrl.sv
`default_nettype none
// tb_pe_array_ctrl: randomized scoreboard bench for pe_array_ctrl with a behavioural array stub. Rev 1.0
module tb_pe_array_ctrl;
  localparam int PE_ROW = 16;
  localparam int VW     = PE_ROW * 8;

  logic            CLK, RST;
  logic            i_Start, i_Op_Valid, i_Res_Ready;
  logic [3:0]      i_Precision;
  logic [15:0]     i_Steps, i_Outputs, i_Op_Bias;
  logic [VW-1:0]   i_Op_Act, i_Op_Weight;
  logic            o_Busy, o_Done, o_Op_Ready, o_Arr_Sel_Bias, o_Arr_Flush, o_Res_Valid, o_Res_Last;
  logic [VW-1:0]   o_Arr_Act, o_Arr_Weight;
  logic [3:0]      o_Arr_Precision;
  logic [15:0]     o_Arr_Bias;
  logic [31:0]     o_Res_Data, i_Arr_Psum;

  pe_array_ctrl dut (
    .CLK(CLK), .RST(RST), .i_Start(i_Start), .i_Precision(i_Precision), .i_Steps(i_Steps),
    .i_Outputs(i_Outputs), .o_Busy(o_Busy), .o_Done(o_Done), .i_Op_Valid(i_Op_Valid),
    .o_Op_Ready(o_Op_Ready), .i_Op_Act(i_Op_Act), .i_Op_Weight(i_Op_Weight), .i_Op_Bias(i_Op_Bias),
    .o_Arr_Act(o_Arr_Act), .o_Arr_Weight(o_Arr_Weight), .o_Arr_Precision(o_Arr_Precision),
    .o_Arr_Bias(o_Arr_Bias), .o_Arr_Sel_Bias(o_Arr_Sel_Bias), .o_Arr_Flush(o_Arr_Flush),
    .i_Arr_Psum(i_Arr_Psum), .o_Res_Valid(o_Res_Valid), .i_Res_Ready(i_Res_Ready),
    .o_Res_Data(o_Res_Data), .o_Res_Last(o_Res_Last)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] w);
    logic [31:0] sum;
    sum = 32'd0;
    for (int r = 0; r < PE_ROW; r++) sum = sum + 32'(a[r*8 +: 8]) * 32'(w[r*8 +: 8]);
    return sum;
  endfunction

  // Array stub: one product stage, then an accumulator that restarts from bias on sel_bias.
  logic [31:0] prod, acc;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      prod <= 32'd0;
      acc  <= 32'd0;
    end else begin
      prod <= dot(o_Arr_Act, o_Arr_Weight);
      if (o_Arr_Flush)         acc <= 32'd0;
      else if (o_Arr_Sel_Bias) acc <= {16'd0, o_Arr_Bias} + prod;
      else                     acc <= acc + prod;
    end
  end
  assign i_Arr_Psum = acc;

  typedef struct { logic [31:0] data; logic last; } res_t;
  res_t        exp_q[$];
  logic [15:0] bias_q[$];
  int          sel_cyc[$];
  int          checks = 0, failures = 0, cyc = 0, last_pop_cyc = -1;
  int          fed, feed_cycles, res_mode;
  bit          abort;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial forever begin
    @(posedge CLK);
    #1;
    if (res_mode == 0)      i_Res_Ready = 1'b1;
    else if (res_mode == 1) i_Res_Ready = 1'($urandom_range(0, 1));
  end

  initial begin : monitor
    res_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (o_Res_Valid && i_Res_Ready) begin
          if (exp_q.size() == 0) chk("res_unexpected", 128'(1), 128'(0));
          else begin
            e = exp_q.pop_front();
            chk("res_data", 128'(o_Res_Data), 128'(e.data));
            chk("res_last", 128'(o_Res_Last), 128'(e.last));
          end
          last_pop_cyc = cyc;
        end
        if (o_Arr_Sel_Bias) begin
          sel_cyc.push_back(cyc);
          if (bias_q.size() == 0) chk("bias_unexpected", 128'(1), 128'(0));
          else chk("arr_bias", 128'(o_Arr_Bias), 128'(bias_q.pop_front()));
        end
      end
    end
  end

  task automatic zero_checks(input string tag);
    chk({tag, "_ctrl_zero"}, 128'({o_Busy, o_Done, o_Op_Ready, o_Arr_Sel_Bias, o_Arr_Flush,
                                   o_Res_Valid, o_Res_Last, o_Arr_Precision, o_Arr_Bias, o_Res_Data}), 128'(0));
    chk({tag, "_act_zero"}, o_Arr_Act, 128'(0));
    chk({tag, "_wgt_zero"}, o_Arr_Weight, 128'(0));
  endtask

  // opm: 0 random operands within precision, 1 all ones, 2 all zeros with bias 5.
  task automatic run_job(input logic [3:0] prec, input int steps, input int outs,
                         input int gap, input int opm, input bit poke);
    logic [VW-1:0] av[$], wv[$], a, w, pa, pw;
    logic [15:0]   bv[$], b;
    logic [31:0]   sum;
    res_t          e;
    int            abits, wbits, total, n;
    bit            v, accd, prev;
    abits = 2 << prec[3:2];
    wbits = 2 << prec[1:0];
    total = steps * outs;
    for (int k = 0; k < outs; k++) begin
      b = (opm == 2) ? 16'd5 : 16'($urandom_range(0, 65535));
      bv.push_back(b);
      bias_q.push_back(b);
      sum = 32'(b);
      for (int s = 0; s < steps; s++) begin
        for (int r = 0; r < PE_ROW; r++) begin
          a[r*8 +: 8] = (opm == 0) ? 8'($urandom_range(0, (1 << abits) - 1)) : (opm == 1) ? 8'd1 : 8'd0;
          w[r*8 +: 8] = (opm == 0) ? 8'($urandom_range(0, (1 << wbits) - 1)) : (opm == 1) ? 8'd1 : 8'd0;
        end
        av.push_back(a);
        wv.push_back(w);
        sum = sum + dot(a, w);
      end
      e.data = sum;
      e.last = (k == outs - 1);
      exp_q.push_back(e);
    end
    @(posedge CLK); #1;
    i_Precision = prec; i_Steps = 16'(steps); i_Outputs = 16'(outs); i_Start = 1'b1;
    @(posedge CLK); #1;
    if (poke) i_Steps = 16'd0;
    else      i_Start = 1'b0;
    @(negedge CLK);
    chk("start_busy", 128'(o_Busy), 128'(1));
    chk("start_flush", 128'(o_Arr_Flush), 128'(1));
    @(posedge CLK); #1;
    i_Start = 1'b0;
    fed = 0; n = 0; prev = 1'b0; pa = '0; pw = '0;
    while (fed < total && !abort && n < 2000) begin
      v = ($urandom_range(0, 99) >= gap);
      i_Op_Valid  = v;
      i_Op_Act    = av[fed];
      i_Op_Weight = wv[fed];
      i_Op_Bias   = (fed % steps == 0) ? bv[fed / steps] : 16'($urandom);
      @(negedge CLK);
      if (!abort) begin
        chk("arr_act", o_Arr_Act, prev ? pa : 128'(0));
        chk("arr_wgt", o_Arr_Weight, prev ? pw : 128'(0));
      end
      if (n == 0) begin
        chk("arr_prec", 128'(o_Arr_Precision), 128'(prec));
        if (poke) chk("start_while_busy", 128'(o_Done), 128'(0));
      end
      accd = v && o_Op_Ready;
      @(posedge CLK); #1;
      prev = accd; pa = av[fed]; pw = wv[fed];
      if (accd) fed++;
      n++;
    end
    i_Op_Valid = 1'b0;
    feed_cycles = n;
    if (!abort) chk("feed_complete", 128'(fed), 128'(total));
  endtask

  task automatic wait_done();
    int  n;
    bit  seen;
    n = 0; seen = 1'b0;
    while (!seen && n < 500) begin
      @(negedge CLK);
      if (o_Done) seen = 1'b1;
      n++;
    end
    chk("done_seen", 128'(seen), 128'(1));
    if (seen) begin
      chk("done_busy_low", 128'(o_Busy), 128'(0));
      chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
      chk("done_after_pop", 128'(cyc), 128'(last_pop_cyc + 1));
      @(negedge CLK);
      chk("done_one_cycle", 128'(o_Done), 128'(0));
    end
  endtask

  initial begin
    int n;
    RST = 1'b1; i_Start = 1'b0; i_Precision = '0; i_Steps = '0; i_Outputs = '0;
    i_Op_Valid = 1'b0; i_Op_Act = '0; i_Op_Weight = '0; i_Op_Bias = '0;
    i_Res_Ready = 1'b0; res_mode = 0; abort = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    zero_checks("reset");
    @(posedge CLK); #1;
    RST = 1'b0;

    run_job(4'b1010, 1, 1, 0, 2, 1'b0);
    wait_done();

    sel_cyc.delete();
    run_job(4'b0000, 4, 3, 0, 1, 1'b0);
    chk("no_bubbles", 128'(feed_cycles), 128'(12));
    wait_done();
    chk("sel_bias_count", 128'(sel_cyc.size()), 128'(3));
    if (sel_cyc.size() == 3) begin
      chk("sel_bias_gap1", 128'(sel_cyc[1] - sel_cyc[0]), 128'(4));
      chk("sel_bias_gap2", 128'(sel_cyc[2] - sel_cyc[1]), 128'(4));
    end

    res_mode = 2; i_Res_Ready = 1'b0;
    fork
      run_job(4'b0000, 4, 3, 0, 1, 1'b0);
      begin
        repeat (22) @(negedge CLK);
        chk("hold_ready_low", 128'(o_Op_Ready), 128'(0));
        chk("hold_two_groups", 128'(fed), 128'(8));
        chk("hold_res_valid", 128'(o_Res_Valid), 128'(1));
        if (exp_q.size() > 0) chk("hold_head", 128'(o_Res_Data), 128'(exp_q[0].data));
        @(posedge CLK); #1;
        res_mode = 0; i_Res_Ready = 1'b1;
      end
    join
    wait_done();

    run_job(4'b0110, 3, 4, 40, 0, 1'b0);
    wait_done();

    @(posedge CLK); #1;
    i_Steps = 16'd0; i_Outputs = 16'd3; i_Start = 1'b1;
    @(posedge CLK); #1;
    i_Start = 1'b0;
    @(negedge CLK);
    chk("zero_steps_done", 128'(o_Done), 128'(1));
    chk("zero_steps_flush", 128'(o_Arr_Flush), 128'(0));
    chk("zero_steps_busy", 128'(o_Busy), 128'(0));
    @(negedge CLK);
    chk("zero_steps_done_pulse", 128'(o_Done), 128'(0));
    chk("zero_steps_no_flush", 128'(o_Arr_Flush), 128'(0));
    @(posedge CLK); #1;
    i_Steps = 16'd2; i_Outputs = 16'd0; i_Start = 1'b1;
    @(posedge CLK); #1;
    i_Start = 1'b0;
    @(negedge CLK);
    chk("zero_outputs_done", 128'(o_Done), 128'(1));
    chk("zero_outputs_busy", 128'(o_Busy), 128'(0));
    run_job(4'b1001, 2, 2, 0, 0, 1'b1);
    wait_done();

    res_mode = 2; i_Res_Ready = 1'b0;
    fork
      run_job(4'b1010, 4, 3, 0, 0, 1'b0);
      begin
        n = 0;
        while (!o_Res_Valid && n < 200) begin
          @(negedge CLK);
          n++;
        end
        chk("rst_fifo_entry", 128'(o_Res_Valid), 128'(1));
        #1;
        RST = 1'b1; abort = 1'b1;
        #1;
        zero_checks("midrun_reset");
        exp_q.delete();
        bias_q.delete();
      end
    join
    @(posedge CLK); #1;
    RST = 1'b0; abort = 1'b0; res_mode = 0;
    run_job(4'b0101, 2, 2, 0, 0, 1'b0);
    wait_done();

    res_mode = 1;
    for (int j = 0; j < 4; j++) begin
      run_job({2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))},
              int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), 30, 0, 1'b0);
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_array_ctrl.md
# pe_array_ctrl

Job sequencer for the 16-row bit-fusion PE array. Accepts a job (precision, vectors per output, output count), streams operand vectors from an upstream buffer into the array with valid/ready flow control, and inserts zero bubbles when starved. It issues the array's flush, bias-select and bias at the array's pipeline-aligned cycle, and captures each finished partial sum into a 2-entry result FIFO. Sits between the operand/weight buffers and the array, and the output/writeback stage.

## Interface
- PE_ROW, 16, array rows
- BITS_ACT, 8, activation bits per row
- BITS_WEIGHT, 8, weight bits per row
- N_BIAS, 16, bias width
- BITS_PSUM, 32, array psum width
- PE_LAT, 1, PE internal pipeline depth (cycles)

Ports (clock and reset first):
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- i_Start  in  1  job start pulse; ignored while o_Busy
- i_Precision  in  4  {act[3:2], wgt[1:0]}: 00=2b, 01=4b, 10=8b; latched at start
- i_Steps  in  16  operand vectors per output
- i_Outputs  in  16  outputs per job
- o_Busy  out  1  job active
- o_Done  out  1  one-cycle job-complete pulse
- i_Op_Valid  in  1  operand vector valid
- o_Op_Ready  out  1  operand vector accepted when valid and ready both high
- i_Op_Act  in  BITS_ACT*PE_ROW  activation vector
- i_Op_Weight  in  BITS_WEIGHT*PE_ROW  weight vector
- i_Op_Bias  in  N_BIAS  bias; sampled only on the first vector of each output
- o_Arr_Act  out  BITS_ACT*PE_ROW  to array i_Act
- o_Arr_Weight  out  BITS_WEIGHT*PE_ROW  to array i_Weight
- o_Arr_Precision  out  4  to array i_Precision
- o_Arr_Bias  out  N_BIAS  to array i_Bias
- o_Arr_Sel_Bias  out  1  to array i_Sel_Bias
- o_Arr_Flush  out  1  to array i_Flush
- i_Arr_Psum  in  BITS_PSUM  from array o_Psum
- o_Res_Valid  out  1  result FIFO not empty
- i_Res_Ready  in  1  result pop
- o_Res_Data  out  BITS_PSUM  FIFO head
- o_Res_Last  out  1  head is the last output of the job

## Operation
- FSM states: IDLE -> FLUSH (1 cycle) -> RUN -> DRAIN -> IDLE.
- IDLE: o_Op_Ready=0. A start with i_Steps=0 or i_Outputs=0 stays IDLE and pulses o_Done the next cycle; no flush, no results.
- FLUSH: o_Arr_Flush=1 for one cycle. o_Arr_Precision is updated from the latch and held until the next job.
- RUN: step counter s and output counter k.
  - When at group start (s=0), o_Op_Ready=1 only if outstanding<2 (outstanding = groups started − results popped). Otherwise o_Op_Ready=1.
  - An accepted vector is registered onto o_Arr_Act/o_Arr_Weight the next cycle. A cycle with no accept drives zeros there (zero contribution).
  - Tag pipeline of depth ACC_LAT=PE_LAT+2 carries {first, last, last_of_job, bias}.
  - The first tag drives o_Arr_Sel_Bias=1 and o_Arr_Bias=bias exactly PE_LAT cycles after its vector is on o_Arr_Act. Otherwise both are 0.
  - When a last tag exits (ACC_LAT cycles after its vector is on o_Arr_Act), i_Arr_Psum is pushed into the FIFO with the last_of_job flag.
  - After the last vector of output i_Outputs−1 is accepted -> DRAIN.
- DRAIN: o_Op_Ready=0. When the tag pipe is empty and the FIFO is empty -> o_Done pulse, IDLE.
- The outstanding≤2 rule guarantees FIFO space at every push. Simultaneous push and pop is legal; count is unchanged.
- Reset (any time, including mid-job): discard job, clear FIFO and tag pipe.

## Timing
- Reset values: every output is 0, including o_Arr_Precision=0000 and o_Res_Data=0.
- Start accepted at edge e: o_Busy=1 and o_Arr_Flush=1 in cycle e+1. o_Op_Ready can first be 1 in cycle e+2.
- Throughput: 1 vector/cycle with no bubbles while the consumer keeps up.
- Latency: last vector accepted at edge a -> o_Res_Valid high from cycle a+1+ACC_LAT (default a+4).
- o_Done is asserted in the cycle after the final pop; o_Busy falls with o_Done.

## Test plan
- 8b/8b, Steps=1, Outputs=1, bias=5, all act/weight=0 -> one result of 5, o_Res_Last=1, o_Done pulse after pop.
- 2b/2b, Steps=4, Outputs=3, constant operands, i_Res_Ready=1 -> 3 results each equal to bias+4×dot; o_Arr_Sel_Bias pulses spaced 4 cycles apart; no bubbles.
- Same job with i_Res_Ready=0 -> o_Op_Ready drops at the 3rd group start; exactly 2 entries held; the 3rd group issues after the first pop; no data loss.
- Random i_Op_Valid gaps, 4b/8b -> results match the gap-free reference; zeros appear on o_Arr_Act in gap cycles.
- i_Steps=0 start -> o_Done at +1 cycle, no o_Arr_Flush; i_Start while busy is ignored.
- RST asserted mid-RUN with 1 FIFO entry -> all outputs 0 immediately; the next job runs cleanly with a flush.
